// File: rtl/uart_rx_if.sv
// Stream-side bundle of the UART receiver: the received word with its valid/ready
// handshake, plus the status pulses and busy flag the host logic watches.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  // The receiver produces words; the consumer drives ready back.
  modport master (
    output data_out,
    output valid,
    output frame_err,
    output overrun,
    output busy,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output ready
  );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: idle-high line, one start bit, MSB-first data, STOP_BITS stop bits,
// no parity. Each bit is sampled once at its middle. Completed words are offered on a
// valid/ready stream. A word arriving while the previous one is still unconsumed is
// dropped and flagged with an overrun pulse. A low stop bit is flagged with a
// frame_err pulse, and the line must then return high before a new start is accepted.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in,
  uart_rx_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_q, rx_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_ctr_q, bit_ctr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 mid_bit;

  assign mid_bit = (cnt_q == MID_CNT);

  // Next-state logic: synchronizer chain, free-running bit-period counter, frame FSM and stream handshake.
  always_comb begin
    sync1_d     = in;
    rx_d        = sync1_q;
    rx_prev_d   = rx_q;
    state_d     = state_q;
    cnt_d       = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    bit_ctr_d   = bit_ctr_q;
    shift_d     = shift_q;
    err_d       = err_q;
    data_d      = data_q;
    valid_d     = valid_q && !rx_if.ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_q && rx_prev_q) begin
          state_d = START;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      START: begin
        if (mid_bit) begin
          if (rx_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_ctr_d = BW'(DATA_BITS - 1);
          end
        end
      end

      DATA: begin
        if (mid_bit) begin
          shift_d[bit_ctr_q] = rx_q;
          if (bit_ctr_q == '0) begin
            state_d   = STOP;
            bit_ctr_d = BW'(STOP_BITS - 1);
          end else begin
            bit_ctr_d = bit_ctr_q - BW'(1);
          end
        end
      end

      STOP: begin
        if (mid_bit) begin
          if (bit_ctr_q != '0) begin
            err_d     = err_q | !rx_q;
            bit_ctr_d = bit_ctr_q - BW'(1);
          end else if (err_q || !rx_q) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end else begin
            state_d = IDLE;
            if (!valid_q || rx_if.ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (rx_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; synchronizer flops reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_q        <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bit_ctr_q   <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_q        <= rx_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      bit_ctr_q   <= bit_ctr_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.data_out  = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = (state_q != IDLE);

endmodule
